// File: rtl/ext_sram_bus.sv
// Multiplexed address/data external SRAM bus controller: two address latch phases,
// then one read or write data phase. Define EXT_SRAM_RDY_EN to add the ext_rdy wait input.
module ext_sram_bus #(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    output logic              ready,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addri,
    input  logic [1:0]        be,
    input  logic [15:0]       dtw,
    output logic [15:0]       dtr,
    output logic              done,
    input  logic [15:0]       din,
    output logic [15:0]       dout,
    output logic              isout,
    output logic              ale0,
    output logic              ale1,
    output logic              oe,
    output logic              we,
    output logic              ble,
    output logic              bhe
`ifdef EXT_SRAM_RDY_EN
    ,
    input  logic              ext_rdy
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_DATA,
        S_END
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:1] addr_q;
    logic              rw_q;
    logic [1:0]        be_q;
    logic [15:0]       dtw_q;
    logic [3:0]        cnt;
    logic [31:1]       addr_ext;
    logic              accept;
    logic              data_last;

    // Halfword address zero-extended so the high latch phase works for any ADDR_W.
    assign addr_ext = 31'(addr_q);
    assign accept   = valid && (state == S_IDLE);

`ifdef EXT_SRAM_RDY_EN
    assign data_last = (cnt == 4'd0) && ext_rdy;
`else
    assign data_last = (cnt == 4'd0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            addr_q <= '0;
            rw_q   <= 1'b0;
            be_q   <= 2'b00;
            dtw_q  <= '0;
            cnt    <= '0;
            dtr    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q <= addri[ADDR_W-1:1];
                rw_q   <= rw;
                be_q   <= (be == 2'b00) ? 2'b11 : be;
                dtw_q  <= dtw;
            end
            if (state == S_ADDR1) begin
                cnt <= 4'(WAIT_CYCLES - 1);
            end else if ((state == S_DATA) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            // Read data is sampled on the edge that ends the final data cycle.
            if ((state == S_DATA) && data_last && !rw_q) begin
                dtr <= din;
            end
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        dout       = '0;
        isout      = 1'b0;
        ale0       = 1'b0;
        ale1       = 1'b0;
        oe         = 1'b0;
        we         = 1'b0;
        ble        = 1'b0;
        bhe        = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (valid) state_next = S_ADDR0;
            end
            S_ADDR0: begin
                dout       = addr_ext[16:1];
                isout      = 1'b1;
                ale0       = 1'b1;
                state_next = S_ADDR1;
            end
            S_ADDR1: begin
                dout       = {1'b0, addr_ext[31:17]};
                isout      = 1'b1;
                ale1       = 1'b1;
                ble        = be_q[0];
                bhe        = be_q[1];
                state_next = S_DATA;
            end
            S_DATA: begin
                ble = be_q[0];
                bhe = be_q[1];
                if (rw_q) begin
                    isout = 1'b1;
                    dout  = dtw_q;
                    we    = 1'b1;
                end else begin
                    oe = 1'b1;
                end
                if (data_last) state_next = S_END;
            end
            S_END: begin
                done = 1'b1;
                ble  = be_q[0];
                bhe  = be_q[1];
                // Write data stays on the bus one extra cycle for SRAM hold time.
                if (rw_q) begin
                    isout = 1'b1;
                    dout  = dtw_q;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ext_sram_bus.sv
// Directed bench for ext_sram_bus: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
module tb_ext_sram_bus;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        valid_a, rw_a, ready_a, done_a, isout_a, ale0_a, ale1_a, oe_a, we_a, ble_a, bhe_a;
    logic [31:0] addri_a;
    logic [1:0]  be_a;
    logic [15:0] dtw_a, din_a, dtr_a, dout_a;
    logic        valid_b, rw_b, ready_b, done_b, isout_b, ale0_b, ale1_b, oe_b, we_b, ble_b, bhe_b;
    logic [31:0] addri_b;
    logic [1:0]  be_b;
    logic [15:0] dtw_b, din_b, dtr_b, dout_b;
`ifdef EXT_SRAM_RDY_EN
    logic        ext_rdy_a, ext_rdy_b;
`endif

    ext_sram_bus #(.ADDR_W(32), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .valid(valid_a), .ready(ready_a), .rw(rw_a),
        .addri(addri_a), .be(be_a), .dtw(dtw_a), .dtr(dtr_a), .done(done_a),
        .din(din_a), .dout(dout_a), .isout(isout_a), .ale0(ale0_a), .ale1(ale1_a),
        .oe(oe_a), .we(we_a), .ble(ble_a), .bhe(bhe_a)
`ifdef EXT_SRAM_RDY_EN
        , .ext_rdy(ext_rdy_a)
`endif
    );

    ext_sram_bus #(.ADDR_W(32), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .valid(valid_b), .ready(ready_b), .rw(rw_b),
        .addri(addri_b), .be(be_b), .dtw(dtw_b), .dtr(dtr_b), .done(done_b),
        .din(din_b), .dout(dout_b), .isout(isout_b), .ale0(ale0_b), .ale1(ale1_b),
        .oe(oe_b), .we(we_b), .ble(ble_b), .bhe(bhe_b)
`ifdef EXT_SRAM_RDY_EN
        , .ext_rdy(ext_rdy_b)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({ready_a, done_a, dtr_a, dout_a, isout_a, ale0_a, ale1_a, oe_a, we_a, ble_a, bhe_a}
            !== {1'b1, 1'b0, 16'h0, 16'h0, 7'h0}) begin
            errors++;
            $display("FAIL reset_a: got rdy=%b done=%b dtr=%h dout=%h strobes=%b%b%b%b%b%b%b, want 1 0 0000 0000 0000000",
                     ready_a, done_a, dtr_a, dout_a, isout_a, ale0_a, ale1_a, oe_a, we_a, ble_a, bhe_a);
        end
        checks++;
        if ({ready_b, done_b, dtr_b, dout_b, isout_b, ale0_b, ale1_b, oe_b, we_b, ble_b, bhe_b}
            !== {1'b1, 1'b0, 16'h0, 16'h0, 7'h0}) begin
            errors++;
            $display("FAIL reset_b: got rdy=%b done=%b dtr=%h dout=%h, want 1 0 0000 0000", ready_b, done_b, dtr_b, dout_b);
        end
        // Start a write, then assert reset in the middle of ADDR0.
        valid_a = 1'b1; rw_a = 1'b1; addri_a = 32'h0003_0004; be_a = 2'b11; dtw_a = 16'hCAFE;
        tick;
        valid_a = 1'b0;
        checks++;
        if (ale0_a !== 1'b1 || dout_a !== 16'h8002) begin
            errors++;
            $display("FAIL reset_pre_addr0: ale0=%b dout=%h, want 1 8002", ale0_a, dout_a);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({ready_a, done_a, dout_a, isout_a, ale0_a, ale1_a, oe_a, we_a, ble_a, bhe_a}
            !== {1'b1, 1'b0, 16'h0, 7'h0}) begin
            errors++;
            $display("FAIL reset_async: rdy=%b done=%b dout=%h isout=%b ale0=%b, want 1 0 0000 0 0",
                     ready_a, done_a, dout_a, isout_a, ale0_a);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_read_basic;
        int cyc, oe_cnt, done_cyc;
        valid_a = 1'b1; rw_a = 1'b0; addri_a = 32'h0002_4686; be_a = 2'b00; din_a = 16'hBEEF;
        tick;
        valid_a = 1'b0; addri_a = '0;
        checks++;
        if (dout_a !== 16'h2343 || ale0_a !== 1'b1 || ale1_a !== 1'b0 || isout_a !== 1'b1 || ready_a !== 1'b0) begin
            errors++;
            $display("FAIL read_addr0: dout=%h ale0=%b ale1=%b isout=%b ready=%b, want 2343 1 0 1 0",
                     dout_a, ale0_a, ale1_a, isout_a, ready_a);
        end
        tick;
        checks++;
        if (dout_a !== 16'h0001 || ale1_a !== 1'b1 || ale0_a !== 1'b0 || ble_a !== 1'b1 || bhe_a !== 1'b1) begin
            errors++;
            $display("FAIL read_addr1: dout=%h ale1=%b ale0=%b ble=%b bhe=%b, want 0001 1 0 1 1",
                     dout_a, ale1_a, ale0_a, ble_a, bhe_a);
        end
        cyc = 2; oe_cnt = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc < 20) begin
            tick;
            cyc++;
            if (oe_a === 1'b1) oe_cnt++;
            if (cyc == 3) begin
                checks++;
                if (oe_a !== 1'b1 || isout_a !== 1'b0 || dout_a !== 16'h0 || we_a !== 1'b0 || ble_a !== 1'b1) begin
                    errors++;
                    $display("FAIL read_data: oe=%b isout=%b dout=%h we=%b ble=%b, want 1 0 0000 0 1",
                             oe_a, isout_a, dout_a, we_a, ble_a);
                end
            end
            if (done_a === 1'b1) done_cyc = cyc;
        end
        checks++;
        if (done_cyc != 4) begin
            errors++;
            $display("FAIL read_done_cycle: got %0d, want 4", done_cyc);
        end
        checks++;
        if (oe_cnt != 1) begin
            errors++;
            $display("FAIL read_oe_len: got %0d, want 1", oe_cnt);
        end
        checks++;
        if (dtr_a !== 16'hBEEF || oe_a !== 1'b0) begin
            errors++;
            $display("FAIL read_dtr: dtr=%h oe=%b, want beef 0", dtr_a, oe_a);
        end
        din_a = 16'h0000;
        tick;
        checks++;
        if (ready_a !== 1'b1 || done_a !== 1'b0 || dtr_a !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_after: ready=%b done=%b dtr=%h, want 1 0 beef", ready_a, done_a, dtr_a);
        end
    endtask

    task automatic test_write_wait3;
        int cyc, we_cnt, done_cyc, bad;
        valid_b = 1'b1; rw_b = 1'b1; addri_b = 32'h0001_0010; be_b = 2'b01; dtw_b = 16'h1234;
        tick;
        valid_b = 1'b0; dtw_b = 16'h0;
        checks++;
        if (dout_b !== 16'h8008 || ale0_b !== 1'b1 || isout_b !== 1'b1) begin
            errors++;
            $display("FAIL write_addr0: dout=%h ale0=%b isout=%b, want 8008 1 1", dout_b, ale0_b, isout_b);
        end
        tick;
        checks++;
        if (dout_b !== 16'h0000 || ale1_b !== 1'b1 || ble_b !== 1'b1 || bhe_b !== 1'b0 || we_b !== 1'b0) begin
            errors++;
            $display("FAIL write_addr1: dout=%h ale1=%b ble=%b bhe=%b we=%b, want 0000 1 1 0 0",
                     dout_b, ale1_b, ble_b, bhe_b, we_b);
        end
        cyc = 2; we_cnt = 0; done_cyc = 0; bad = 0;
        while (done_cyc == 0 && cyc < 20) begin
            tick;
            cyc++;
            if (we_b === 1'b1) begin
                we_cnt++;
                if (dout_b !== 16'h1234 || isout_b !== 1'b1 || ble_b !== 1'b1 || bhe_b !== 1'b0 ||
                    ale0_b !== 1'b0 || ale1_b !== 1'b0 || oe_b !== 1'b0) bad++;
            end
            if (done_b === 1'b1) done_cyc = cyc;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write_data_phase: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (we_cnt != 3) begin
            errors++;
            $display("FAIL write_we_len: got %0d, want 3", we_cnt);
        end
        checks++;
        if (done_cyc != 6) begin
            errors++;
            $display("FAIL write_done_cycle: got %0d, want 6", done_cyc);
        end
        checks++;
        if (dout_b !== 16'h1234 || isout_b !== 1'b1 || we_b !== 1'b0 || ble_b !== 1'b1 || bhe_b !== 1'b0) begin
            errors++;
            $display("FAIL write_end_hold: dout=%h isout=%b we=%b ble=%b bhe=%b, want 1234 1 0 1 0",
                     dout_b, isout_b, we_b, ble_b, bhe_b);
        end
        tick;
        checks++;
        if (isout_b !== 1'b0 || dout_b !== 16'h0 || ready_b !== 1'b1 || ble_b !== 1'b0) begin
            errors++;
            $display("FAIL write_after: isout=%b dout=%h ready=%b ble=%b, want 0 0000 1 0",
                     isout_b, dout_b, ready_b, ble_b);
        end
    endtask

    task automatic test_back_to_back;
        int acc, nd, d1, d2;
        logic drop;
        acc = 0; nd = 0; d1 = 0; d2 = 0; drop = 1'b0;
        valid_a = 1'b1; rw_a = 1'b0; addri_a = 32'h0000_0100; be_a = 2'b11; din_a = 16'h1111;
        for (int c = 1; c <= 14; c++) begin
            if (ready_a === 1'b1 && valid_a === 1'b1) begin
                acc++;
                if (acc == 2) drop = 1'b1;
            end
            tick;
            if (drop) begin
                valid_a = 1'b0;
                drop = 1'b0;
            end
            if (done_a === 1'b1) begin
                nd++;
                if (nd == 1) begin
                    d1 = c;
                    checks++;
                    if (dtr_a !== 16'h1111) begin
                        errors++;
                        $display("FAIL b2b_dtr1: got %h, want 1111", dtr_a);
                    end
                    din_a = 16'h2222;
                end else begin
                    d2 = c;
                    checks++;
                    if (dtr_a !== 16'h2222) begin
                        errors++;
                        $display("FAIL b2b_dtr2: got %h, want 2222", dtr_a);
                    end
                end
            end
        end
        valid_a = 1'b0;
        checks++;
        if (nd != 2 || acc != 2) begin
            errors++;
            $display("FAIL b2b_count: done pulses=%0d accepts=%0d, want 2 2", nd, acc);
        end
        checks++;
        if (d1 != 4 || d2 - d1 != 5) begin
            errors++;
            $display("FAIL b2b_spacing: first done=%0d gap=%0d, want 4 5", d1, d2 - d1);
        end
    endtask

    task automatic test_reset_abort;
        int saw, cyc, done_cyc;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (dtr_a !== 16'h0) begin
            errors++;
            $display("FAIL abort_dtr_clear: got %h, want 0000", dtr_a);
        end
        valid_a = 1'b1; rw_a = 1'b0; addri_a = 32'h0000_0200; be_a = 2'b11; din_a = 16'h5555;
        tick;
        valid_a = 1'b0;
        tick;
        tick;
        checks++;
        if (oe_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_data: oe=%b, want 1", oe_a);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ready_a, done_a, dtr_a, oe_a, ble_a, bhe_a, isout_a} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
            errors++;
            $display("FAIL abort_async: ready=%b done=%b dtr=%h oe=%b ble=%b, want 1 0 0000 0 0",
                     ready_a, done_a, dtr_a, oe_a, ble_a);
        end
        tick;
        reset = 1'b0;
        saw = 0;
        repeat (8) begin
            tick;
            if (done_a === 1'b1) saw++;
        end
        checks++;
        if (saw != 0 || dtr_a !== 16'h0) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d dtr=%h, want 0 0000", saw, dtr_a);
        end
        valid_a = 1'b1; addri_a = 32'h0000_0300; din_a = 16'hA5A5;
        tick;
        valid_a = 1'b0;
        cyc = 1; done_cyc = 0;
        while (done_cyc == 0 && cyc < 20) begin
            tick;
            cyc++;
            if (done_a === 1'b1) done_cyc = cyc;
        end
        checks++;
        if (done_cyc != 4 || dtr_a !== 16'hA5A5) begin
            errors++;
            $display("FAIL abort_recover: done cycle=%0d dtr=%h, want 4 a5a5", done_cyc, dtr_a);
        end
        tick;
    endtask

`ifdef EXT_SRAM_RDY_EN
    task automatic test_ext_rdy;
        int cyc, oe_cnt, done_cyc;
        ext_rdy_a = 1'b0;
        valid_a = 1'b1; rw_a = 1'b0; addri_a = 32'h0000_0400; be_a = 2'b10; din_a = 16'h7777;
        tick;
        valid_a = 1'b0;
        cyc = 1; oe_cnt = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc < 20) begin
            tick;
            cyc++;
            if (oe_a === 1'b1) oe_cnt++;
            if (done_a === 1'b1) done_cyc = cyc;
            if (cyc == 5) ext_rdy_a = 1'b1;
        end
        checks++;
        if (oe_cnt != 3 || done_cyc != 6 || dtr_a !== 16'h7777) begin
            errors++;
            $display("FAIL ext_rdy_stretch: oe cycles=%0d done cycle=%0d dtr=%h, want 3 6 7777",
                     oe_cnt, done_cyc, dtr_a);
        end
        ext_rdy_a = 1'b1;
        tick;
    endtask
`endif

    initial begin
        reset = 1'b1;
        valid_a = 1'b0; rw_a = 1'b0; addri_a = '0; be_a = 2'b00; dtw_a = '0; din_a = '0;
        valid_b = 1'b0; rw_b = 1'b0; addri_b = '0; be_b = 2'b00; dtw_b = '0; din_b = '0;
`ifdef EXT_SRAM_RDY_EN
        ext_rdy_a = 1'b1;
        ext_rdy_b = 1'b1;
`endif
        test_reset();
        test_read_basic();
        test_write_wait3();
        test_back_to_back();
        test_reset_abort();
`ifdef EXT_SRAM_RDY_EN
        test_ext_rdy();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ext_sram_bus.md
# ext_sram_bus

Parametrised controller for the external multiplexed-address/data asynchronous SRAM bus. It sits between the core's memory request port and the board-level latch/SRAM pins. It time-multiplexes a wide address over a 16-bit bus in two latch phases, then performs one read or write data phase of configurable length with byte-lane enables. Successor to the fixed 3-phase single-wait controller: adds a parameter for address width, a parameter for wait-state count, byte enables, a ready/valid request handshake and back-to-back operation.

## Interface

Parameters:
- ADDR_W, 32: request address width, legal 17..32; bit 0 ignored (halfword addressing).
- WAIT_CYCLES, 1: number of data-phase cycles, legal 1..15.

Ports:
- clk  in  1  sole clock; all state and outputs update on posedge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- valid  in  1  request present.
- ready  out  1  controller can accept; high only in IDLE.
- rw  in  1  1 = write, 0 = read.
- addri  in  ADDR_W  byte address.
- be  in  2  byte enables {high, low}; 2'b00 treated as 2'b11.
- dtw  in  16  write data.
- dtr  out  16  registered read data; valid while done=1, held until next read completes.
- done  out  1  one-cycle completion pulse.
- din  in  16  bus input from pads.
- dout  out  16  bus output to pads.
- isout  out  1  pad output enable (1 = drive dout).
- ale0, ale1  out  1  address latch strobes, low/high half.
- oe, we  out  1  SRAM output/write enable, active high.
- ble, bhe  out  1  byte lane enables, active high.

## Operation

- Accept: a request transfers when valid && ready at a posedge. addri, rw, be and dtw are captured. Inputs are ignored at all other times.
- States: IDLE → ADDR0 → ADDR1 → DATA (WAIT_CYCLES cycles, counter) → END → IDLE.
- IDLE: all strobes 0, isout 0, dout 0, ready 1.
- ADDR0: dout = addr[16:1], isout 1, ale0 1.
- ADDR1: dout = zero-extended addr[ADDR_W-1:17], isout 1, ale1 1, ble/bhe = captured be.
- DATA:
  - Write: isout 1, dout = dtw, we 1.
  - Read: isout 0, dout 0, oe 1.
  - ble/bhe held. The counter loads WAIT_CYCLES-1 on entry and decrements; exit when 0 (and see Configuration).
- END:
  - we 0, oe 0, done 1.
  - Write: isout stays 1 with dout = dtw for data hold.
  - Read: isout 0.
  - ble/bhe held.
- Read capture: dtr loads din on the posedge leaving the last DATA cycle.
- After END the controller returns to IDLE. A new request can be accepted in that IDLE cycle, giving one idle bus cycle minimum between operations.
- Reset mid-operation: state returns to IDLE asynchronously, all outputs (including dtr) go to 0, and no done is produced for the aborted request.

## Timing

- Reset values: ready 1; done, dtr, dout, isout, ale0, ale1, oe, we, ble, bhe all 0.
- Accept at edge n; ADDR0 during cycle n+1; ADDR1 during n+2; DATA during n+3 .. n+2+W; END/done during n+3+W (W = WAIT_CYCLES, no stretching).
- Latency accept→done = 3+W cycles. Throughput is one operation per 4+W cycles.
- ale0/ale1 are never high simultaneously. we and oe are never high simultaneously. we is never high while ale0 or ale1 is high.

## Configuration

- EXT_SRAM_RDY_EN defined:
  - Adds input ext_rdy (1 bit).
  - DATA exits only when the counter is 0 and ext_rdy is sampled 1. Otherwise DATA extends one cycle at a time with all outputs held.
  - ext_rdy is ignored in other states.
- EXT_SRAM_RDY_EN undefined: the port is absent and the DATA length is exactly WAIT_CYCLES.

## Test plan

- Reset: assert reset asynchronously mid-cycle → all outputs 0 and ready 1 before the next edge.
- Read, ADDR_W=32, W=1, addri=0x0002_4686, din=0xBEEF → ADDR0 dout=0x2343, ADDR1 dout=0x0001, oe for 1 cycle, done at accept+4, dtr=0xBEEF.
- Write, W=3, be=2'b01, dtw=0x1234 → we high exactly 3 cycles, ble=1, bhe=0, dout=0x1234 in DATA and END, done at accept+6.
- Back-to-back: valid held high with two requests → second accepted in the IDLE cycle after the first done; two done pulses 5 cycles apart (W=1).
- Reset asserted during DATA of a read → no done pulse, dtr stays 0; next request completes normally.
- With EXT_SRAM_RDY_EN, W=1, ext_rdy low for 2 cycles → oe high 3 cycles, done at accept+6.
